// File: rtl/pipe_pkg.sv
// pipe_pkg: shared types and helpers for the pipe_chain pipeline-register block.
//   pipe_entry_t - one stage's contents (valid, wen, tag, data). Tag and data
//                  fields are sized to TAG_MAX_W / DATA_MAX_W; pipe_chain
//                  zero-extends into them and truncates out of them, so its
//                  TAG_W and WIDTH parameters must not exceed these maxima.
//   TAG_ZERO     - the register-zero tag, which never produces a lookup hit.
//   sidx_w()     - width of a stage index, max(1, clog2(depth)).
package pipe_pkg;

    localparam int unsigned DATA_MAX_W = 64;
    localparam int unsigned TAG_MAX_W  = 16;

    localparam logic [TAG_MAX_W-1:0] TAG_ZERO = '0;

    typedef struct packed {
        logic                  valid;
        logic                  wen;
        logic [TAG_MAX_W-1:0]  tag;
        logic [DATA_MAX_W-1:0] data;
    } pipe_entry_t;

    function automatic int unsigned sidx_w(input int unsigned depth);
        return (depth <= 1) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: a single pipeline stage register.
// Ports:
//   clk, rst  - clock and synchronous active-high reset (clears the whole entry)
//   load_i    - capture entry_i
//   bubble_i  - advance with no source: clear valid, keep tag/data/wen
//   kill_i    - flush: clear valid, overrides load and bubble
//   entry_i   - incoming entry
//   entry_o   - current stage contents
// With none of load/bubble/kill asserted the stage holds.
module pipe_stage_reg
    import pipe_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load_i,
    input  logic        bubble_i,
    input  logic        kill_i,
    input  pipe_entry_t entry_i,
    output pipe_entry_t entry_o
);

    pipe_entry_t entry_q, entry_d;

    always_comb begin
        entry_d = entry_q;
        if (load_i) begin
            entry_d = entry_i;
        end else if (bubble_i) begin
            entry_d.valid = 1'b0;
        end
        if (kill_i) begin
            entry_d.valid = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            entry_q <= '0;
        end else begin
            entry_q <= entry_d;
        end
    end

    assign entry_o = entry_q;

endmodule

// File: rtl/pipe_chain.sv
// pipe_chain: DEPTH-stage pipeline-register chain (stage 0 youngest) with
// per-stage stall and backward stall propagation, bubble collapsing,
// younger-stage flush and LOOKUPS parallel forwarding tag-match ports.
// Ports:
//   clk, rst                  - clock, synchronous active-high reset
//   in_valid/in_ready         - entry offer to stage 0 (in_ready combinational)
//   in_data/in_tag/in_wen     - offered entry contents
//   stall_i[k]                - hold request for stage k
//   flush_i[k]                - kill stages 0..k at the next edge
//   out_valid/out_fire        - last stage valid / leaving this cycle
//   out_data/out_tag/out_wen  - last stage contents
//   lk_tag/lk_hit/lk_stage/lk_data - per-port youngest valid writer of a tag
//   occupancy                 - number of valid stages
// Optional macro PIPE_CHAIN_STATS_EN adds saturating 32-bit counters
// stat_stall, stat_bubble and stat_flush.
module pipe_chain
    import pipe_pkg::*;
#(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned DEPTH   = 3,
    parameter int unsigned TAG_W   = 5,
    parameter int unsigned LOOKUPS = 2,
    localparam int unsigned SIDX_W = sidx_w(DEPTH)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_data,
    input  logic [TAG_W-1:0]           in_tag,
    input  logic                       in_wen,
    input  logic [DEPTH-1:0]           stall_i,
    input  logic [DEPTH-1:0]           flush_i,
    output logic                       out_valid,
    output logic                       out_fire,
    output logic [WIDTH-1:0]           out_data,
    output logic [TAG_W-1:0]           out_tag,
    output logic                       out_wen,
`ifdef PIPE_CHAIN_STATS_EN
    output logic [31:0]                stat_stall,
    output logic [31:0]                stat_bubble,
    output logic [31:0]                stat_flush,
`endif
    input  logic [LOOKUPS*TAG_W-1:0]   lk_tag,
    output logic [LOOKUPS-1:0]         lk_hit,
    output logic [LOOKUPS*SIDX_W-1:0]  lk_stage,
    output logic [LOOKUPS*WIDTH-1:0]   lk_data,
    output logic [SIDX_W:0]            occupancy
);

    pipe_entry_t      st [DEPTH];
    logic [DEPTH-1:0] stage_valid;
    logic [DEPTH-1:0] hold;
    logic [DEPTH-1:0] kill;

    always_comb begin
        for (int k = 0; k < int'(DEPTH); k++) begin
            stage_valid[k] = st[k].valid;
        end
    end

    // Stall propagates backwards only through occupied stages, so an empty
    // stage absorbs the stall and bubbles get squeezed out.
    always_comb begin
        hold = '0;
        hold[DEPTH-1] = stall_i[DEPTH-1];
        for (int k = int'(DEPTH) - 2; k >= 0; k--) begin
            hold[k] = stall_i[k] | (hold[k+1] & stage_valid[k]);
        end
    end

    // Stage k is killed when any flush bit at index >= k is set.
    always_comb begin
        logic acc;
        acc  = 1'b0;
        kill = '0;
        for (int k = int'(DEPTH) - 1; k >= 0; k--) begin
            acc     = acc | flush_i[k];
            kill[k] = acc;
        end
    end

    assign in_ready = ~hold[0];

    for (genvar g = 0; g < int'(DEPTH); g++) begin : g_stage
        pipe_entry_t src;
        logic        src_v;

        if (g == 0) begin : g_head
            always_comb begin
                src       = '0;
                src.valid = 1'b1;
                src.wen   = in_wen;
                src.tag   = TAG_MAX_W'(in_tag);
                src.data  = DATA_MAX_W'(in_data);
            end
            assign src_v = in_valid;
        end else begin : g_body
            assign src   = st[g-1];
            assign src_v = stage_valid[g-1] & ~hold[g-1];
        end

        pipe_stage_reg u_reg (
            .clk      (clk),
            .rst      (rst),
            .load_i   (~hold[g] & src_v),
            .bubble_i (~hold[g] & ~src_v),
            .kill_i   (kill[g]),
            .entry_i  (src),
            .entry_o  (st[g])
        );
    end

    assign out_valid = st[DEPTH-1].valid;
    assign out_fire  = st[DEPTH-1].valid & ~stall_i[DEPTH-1];
    assign out_data  = WIDTH'(st[DEPTH-1].data);
    assign out_tag   = TAG_W'(st[DEPTH-1].tag);
    assign out_wen   = st[DEPTH-1].wen;

    // Upper bits of the package-wide entry fields are zero-filled padding.
    logic unused_last;
    assign unused_last = ^st[DEPTH-1];

    // Scan oldest to youngest so the youngest candidate is the last writer.
    always_comb begin
        lk_hit   = '0;
        lk_stage = '0;
        lk_data  = '0;
        for (int j = 0; j < int'(LOOKUPS); j++) begin
            for (int k = int'(DEPTH) - 1; k >= 0; k--) begin
                if (st[k].valid && st[k].wen &&
                    (TAG_MAX_W'(lk_tag[j*TAG_W +: TAG_W]) != TAG_ZERO) &&
                    (st[k].tag == TAG_MAX_W'(lk_tag[j*TAG_W +: TAG_W]))) begin
                    lk_hit[j]                    = 1'b1;
                    lk_stage[j*SIDX_W +: SIDX_W] = SIDX_W'(k);
                    lk_data[j*WIDTH +: WIDTH]    = WIDTH'(st[k].data);
                end
            end
        end
    end

    always_comb begin
        occupancy = '0;
        for (int k = 0; k < int'(DEPTH); k++) begin
            occupancy = occupancy + {{SIDX_W{1'b0}}, stage_valid[k]};
        end
    end

`ifdef PIPE_CHAIN_STATS_EN
    logic [31:0]   stat_stall_q, stat_stall_d;
    logic [31:0]   stat_bubble_q, stat_bubble_d;
    logic [31:0]   stat_flush_q, stat_flush_d;
    logic [SIDX_W:0] flush_cnt;
    logic [32:0]   flush_sum;

    always_comb begin
        flush_cnt = '0;
        for (int k = 0; k < int'(DEPTH); k++) begin
            flush_cnt = flush_cnt + {{SIDX_W{1'b0}}, stage_valid[k] & kill[k]};
        end
        flush_sum = {1'b0, stat_flush_q} + 33'(flush_cnt);

        stat_stall_d  = stat_stall_q;
        stat_bubble_d = stat_bubble_q;
        if (in_valid && !in_ready && (stat_stall_q != '1)) begin
            stat_stall_d = stat_stall_q + 32'd1;
        end
        if (!out_valid && (stat_bubble_q != '1)) begin
            stat_bubble_d = stat_bubble_q + 32'd1;
        end
        stat_flush_d = flush_sum[32] ? '1 : flush_sum[31:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stat_stall_q  <= '0;
            stat_bubble_q <= '0;
            stat_flush_q  <= '0;
        end else begin
            stat_stall_q  <= stat_stall_d;
            stat_bubble_q <= stat_bubble_d;
            stat_flush_q  <= stat_flush_d;
        end
    end

    assign stat_stall  = stat_stall_q;
    assign stat_bubble = stat_bubble_q;
    assign stat_flush  = stat_flush_q;
`endif

endmodule

// File: tb/tb_pipe_chain.sv
// Self-checking bench for pipe_chain (default parameters). A reference model
// of the stage array predicts every cycle; retiring entries are queued in a
// scoreboard that a separate monitor drains whenever the DUT fires.
`timescale 1ns/1ps
module tb_pipe_chain;

    localparam int unsigned WIDTH   = 32;
    localparam int unsigned DEPTH   = 3;
    localparam int unsigned TAG_W   = 5;
    localparam int unsigned LOOKUPS = 2;
    localparam int unsigned SIDX_W  = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                      rst;
    logic                      in_valid;
    logic                      in_ready;
    logic [WIDTH-1:0]          in_data;
    logic [TAG_W-1:0]          in_tag;
    logic                      in_wen;
    logic [DEPTH-1:0]          stall_i;
    logic [DEPTH-1:0]          flush_i;
    logic                      out_valid;
    logic                      out_fire;
    logic [WIDTH-1:0]          out_data;
    logic [TAG_W-1:0]          out_tag;
    logic                      out_wen;
    logic [LOOKUPS*TAG_W-1:0]  lk_tag;
    logic [LOOKUPS-1:0]        lk_hit;
    logic [LOOKUPS*SIDX_W-1:0] lk_stage;
    logic [LOOKUPS*WIDTH-1:0]  lk_data;
    logic [SIDX_W:0]           occupancy;
`ifdef PIPE_CHAIN_STATS_EN
    logic [31:0] stat_stall, stat_bubble, stat_flush;
`endif

    pipe_chain #(
        .WIDTH   (WIDTH),
        .DEPTH   (DEPTH),
        .TAG_W   (TAG_W),
        .LOOKUPS (LOOKUPS)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_tag    (in_tag),
        .in_wen    (in_wen),
        .stall_i   (stall_i),
        .flush_i   (flush_i),
        .out_valid (out_valid),
        .out_fire  (out_fire),
        .out_data  (out_data),
        .out_tag   (out_tag),
        .out_wen   (out_wen),
`ifdef PIPE_CHAIN_STATS_EN
        .stat_stall  (stat_stall),
        .stat_bubble (stat_bubble),
        .stat_flush  (stat_flush),
`endif
        .lk_tag    (lk_tag),
        .lk_hit    (lk_hit),
        .lk_stage  (lk_stage),
        .lk_data   (lk_data),
        .occupancy (occupancy)
    );

    typedef struct packed {
        logic        rst;
        logic        iv;
        logic [31:0] d;
        logic [4:0]  t;
        logic        w;
        logic [2:0]  stall;
        logic [2:0]  flush;
        logic [4:0]  lk0;
        logic [4:0]  lk1;
    } stim_t;

    int checks   = 0;
    int failures = 0;

    // Reference model: contents of each stage.
    bit          mv [DEPTH];
    bit          mw [DEPTH];
    logic [4:0]  mt [DEPTH];
    logic [31:0] md [DEPTH];
    longint unsigned m_stall, m_bubble, m_flush;

    logic [37:0] sb_q [$];

    // Values seen at the last sample point, for directed constant checks.
    logic        last_ready, last_ov;
    logic [31:0] last_data;
    logic [4:0]  last_tag;
    logic        last_wen;
    logic [2:0]  last_occ;
    logic [1:0]  last_hit;
    logic [3:0]  last_stage;
    logic [63:0] last_ldata;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic longint unsigned sat32(input longint unsigned v);
        return (v > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : v;
    endfunction

    function automatic bit [DEPTH-1:0] model_hold(input logic [DEPTH-1:0] stall);
        bit [DEPTH-1:0] h;
        h[DEPTH-1] = stall[DEPTH-1];
        for (int k = DEPTH - 2; k >= 0; k--) h[k] = stall[k] | (h[k+1] & mv[k]);
        return h;
    endfunction

    task automatic model_step(input stim_t s, input bit [DEPTH-1:0] h);
        bit          nv [DEPTH];
        bit          nw [DEPTH];
        logic [4:0]  nt [DEPTH];
        logic [31:0] nd [DEPTH];
        int f, killed;
        if (s.rst) begin
            for (int k = 0; k < DEPTH; k++) begin
                mv[k] = 0; mw[k] = 0; mt[k] = '0; md[k] = '0;
            end
            m_stall = 0; m_bubble = 0; m_flush = 0;
            return;
        end
        for (int k = 0; k < DEPTH; k++) begin
            nv[k] = mv[k]; nw[k] = mw[k]; nt[k] = mt[k]; nd[k] = md[k];
        end
        for (int k = 0; k < DEPTH; k++) begin
            if (!h[k]) begin
                if (k == 0) begin
                    if (s.iv) begin nv[0] = 1; nw[0] = s.w; nt[0] = s.t; nd[0] = s.d; end
                    else nv[0] = 0;
                end else if (mv[k-1] && !h[k-1]) begin
                    nv[k] = 1; nw[k] = mw[k-1]; nt[k] = mt[k-1]; nd[k] = md[k-1];
                end else begin
                    nv[k] = 0;
                end
            end
        end
        f = -1;
        for (int k = 0; k < DEPTH; k++) if (s.flush[k]) f = k;
        killed = 0;
        for (int k = 0; k <= f; k++) begin
            if (mv[k]) killed++;
            nv[k] = 0;
        end
        m_stall  = sat32(m_stall + ((s.iv && h[0]) ? 1 : 0));
        m_bubble = sat32(m_bubble + (mv[DEPTH-1] ? 0 : 1));
        m_flush  = sat32(m_flush + longint'(killed));
        for (int k = 0; k < DEPTH; k++) begin
            mv[k] = nv[k]; mw[k] = nw[k]; mt[k] = nt[k]; md[k] = nd[k];
        end
    endtask

    // Apply one cycle of stimulus, check everything against the model, step it.
    task automatic drive(input stim_t s);
        bit [DEPTH-1:0] h;
        logic [4:0]  lt [2];
        bit          eh [2];
        logic [1:0]  es [2];
        logic [31:0] ed [2];
        int occ;
        rst = s.rst; in_valid = s.iv; in_data = s.d; in_tag = s.t; in_wen = s.w;
        stall_i = s.stall; flush_i = s.flush; lk_tag = {s.lk1, s.lk0};
        h = model_hold(s.stall);
        if (mv[DEPTH-1] && !s.stall[DEPTH-1])
            sb_q.push_back({mw[DEPTH-1], mt[DEPTH-1], md[DEPTH-1]});
        lt[0] = s.lk0; lt[1] = s.lk1;
        for (int j = 0; j < 2; j++) begin
            eh[j] = 0; es[j] = '0; ed[j] = '0;
            for (int k = 0; k < DEPTH; k++) begin
                if (!eh[j] && lt[j] != 0 && mv[k] && mw[k] && mt[k] == lt[j]) begin
                    eh[j] = 1; es[j] = 2'(k); ed[j] = md[k];
                end
            end
        end
        occ = 0;
        for (int k = 0; k < DEPTH; k++) occ += int'(mv[k]);
        @(negedge clk);
        last_ready = in_ready; last_ov = out_valid; last_data = out_data;
        last_tag = out_tag; last_wen = out_wen; last_occ = occupancy;
        last_hit = lk_hit; last_stage = lk_stage; last_ldata = lk_data;
        chk("in_ready", in_ready, !h[0]);
        chk("out_valid", out_valid, mv[DEPTH-1]);
        chk("out_fire", out_fire, mv[DEPTH-1] & !s.stall[DEPTH-1]);
        chk("out_entry", {out_wen, out_tag, out_data}, {mw[DEPTH-1], mt[DEPTH-1], md[DEPTH-1]});
        chk("occupancy", occupancy, occ);
        chk("lk_hit", lk_hit, {eh[1], eh[0]});
        chk("lk_stage", lk_stage, {es[1], es[0]});
        chk("lk_data", lk_data, {ed[1], ed[0]});
`ifdef PIPE_CHAIN_STATS_EN
        chk("stat_stall", stat_stall, m_stall);
        chk("stat_bubble", stat_bubble, m_bubble);
        chk("stat_flush", stat_flush, m_flush);
`endif
        @(posedge clk);
        model_step(s, h);
        #1;
    endtask

    task automatic cyc(input logic r, input logic iv, input logic [31:0] d, input logic [4:0] t,
                       input logic w, input logic [2:0] st, input logic [2:0] fl,
                       input logic [4:0] l0, input logic [4:0] l1);
        stim_t s;
        s.rst = r; s.iv = iv; s.d = d; s.t = t; s.w = w;
        s.stall = st; s.flush = fl; s.lk0 = l0; s.lk1 = l1;
        drive(s);
    endtask

    task automatic push(input logic [31:0] d, input logic [4:0] t, input logic w);
        cyc(1'b0, 1'b1, d, t, w, 3'b000, 3'b000, 5'd0, 5'd0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 32'd0, 5'd0, 1'b0, 3'b000, 3'b000, 5'd0, 5'd0);
    endtask

    // Monitor: pops one expected entry per DUT fire.
    always @(negedge clk) begin
        logic [37:0] exp_e;
        if (out_fire === 1'b1) begin
            if (sb_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL sb_unexpected: got %0h expected nothing at %0t",
                         {out_wen, out_tag, out_data}, $time);
            end else begin
                exp_e = sb_q.pop_front();
                chk("sb_out", {out_wen, out_tag, out_data}, exp_e);
            end
        end
    end

    initial begin
        bit saw_early;
        stim_t s;
        rst = 1'b1; in_valid = 0; in_data = '0; in_tag = '0; in_wen = 0;
        stall_i = '0; flush_i = '0; lk_tag = '0;
        for (int k = 0; k < DEPTH; k++) begin mv[k] = 0; mw[k] = 0; mt[k] = '0; md[k] = '0; end
        m_stall = 0; m_bubble = 0; m_flush = 0;
        @(posedge clk);
        #1;

        // Reset and in-order streaming with DEPTH-cycle latency.
        cyc(1, 0, 0, 0, 0, 3'b000, 3'b000, 0, 0);
        cyc(1, 0, 0, 0, 0, 3'b000, 3'b000, 0, 0);
        push(32'h11, 5'd3, 1);
        chk("rst_ready", last_ready, 1);
        chk("rst_out", {last_ov, last_wen, last_tag, last_data}, 0);
        chk("rst_occ", last_occ, 0);
        saw_early = 0;
        push(32'h22, 5'd4, 1);
        saw_early |= last_ov;
        push(32'h33, 5'd5, 1);
        saw_early |= last_ov;
        idle(1);
        chk("latency_early", saw_early, 0);
        chk("latency_a", {last_ov, last_tag, last_data}, {1'b1, 5'd3, 32'h11});
        chk("full_occ", last_occ, 3);
        idle(2);

        // Stall of the last stage back-propagates through a full pipe.
        push(32'h44, 5'd1, 1);
        push(32'h55, 5'd2, 1);
        push(32'h66, 5'd3, 1);
        cyc(0, 1, 32'h77, 5'd4, 1, 3'b100, 3'b000, 0, 0);
        chk("stall_ready0", last_ready, 0);
        cyc(0, 1, 32'h77, 5'd4, 1, 3'b100, 3'b000, 0, 0);
        chk("stall_ready1", last_ready, 0);
        chk("stall_hold", {last_occ, last_data}, {3'd3, 32'h44});
        idle(3);
        // Only the last stage valid: the stall is absorbed by empty stages.
        push(32'h88, 5'd6, 1);
        idle(2);
        cyc(0, 1, 32'h99, 5'd7, 1, 3'b100, 3'b000, 0, 0);
        chk("absorb_ready0", last_ready, 1);
        cyc(0, 1, 32'hA1, 5'd7, 1, 3'b100, 3'b000, 0, 0);
        chk("absorb_ready1", last_ready, 1);
        cyc(0, 1, 32'hA2, 5'd7, 1, 3'b100, 3'b000, 0, 0);
        chk("absorb_full", last_ready, 0);
        idle(4);

        // Flush of stages 0..1 with an input offered.
        push(32'hE1, 5'd1, 1);
        push(32'hE2, 5'd2, 1);
        cyc(0, 1, 32'hDD, 5'd3, 1, 3'b000, 3'b010, 0, 0);
        chk("flush_ready", last_ready, 1);
        idle(1);
        chk("flush_occ", last_occ, 1);
        chk("flush_out", {last_ov, last_data}, {1'b1, 32'hE1});
        idle(2);

        // Lookup priority, tag zero and wen=0.
        push(32'hBB, 5'd5, 1);
        push(32'hCC, 5'd6, 0);
        push(32'hAA, 5'd5, 1);
        cyc(0, 0, 0, 0, 0, 3'b111, 3'b000, 5'd5, 5'd6);
        chk("lk_young", {last_hit, last_stage, last_ldata},
            {2'b01, 4'b0000, 32'h0, 32'hAA});
        cyc(0, 1, 32'hDD, 5'd0, 1, 3'b000, 3'b000, 5'd5, 5'd0);
        cyc(0, 0, 0, 0, 0, 3'b111, 3'b000, 5'd0, 5'd5);
        chk("lk_zero", {last_hit, last_stage, last_ldata},
            {2'b10, 4'b0100, 32'hAA, 32'h0});
        idle(3);

        // Reset mid-operation with a stalled full pipe.
        push(32'hF1, 5'd1, 1);
        push(32'hF2, 5'd2, 1);
        push(32'hF3, 5'd3, 1);
        cyc(0, 0, 0, 0, 0, 3'b100, 3'b000, 0, 0);
        cyc(1, 1, 32'hF4, 5'd4, 1, 3'b100, 3'b000, 0, 0);
        idle(1);
        chk("midrst_out", {last_ov, last_wen, last_tag, last_data}, 0);
        chk("midrst_occ", {last_ready, last_occ}, {1'b1, 3'd0});

        // Stall cycles and flushed entries (counter checks when enabled).
        for (int i = 0; i < 4; i++) cyc(0, 1, 32'h5A, 5'd1, 1, 3'b001, 3'b000, 0, 0);
        push(32'h61, 5'd1, 1);
        push(32'h62, 5'd2, 1);
        cyc(0, 0, 0, 0, 0, 3'b000, 3'b010, 0, 0);
        idle(1);
`ifdef PIPE_CHAIN_STATS_EN
        chk("stat_stall4", stat_stall, 4);
        chk("stat_flush2", stat_flush, 2);
`endif
        idle(2);

        // Randomized traffic.
        for (int i = 0; i < 1500; i++) begin
            s.rst   = ($urandom_range(0, 199) == 0);
            s.iv    = ($urandom_range(0, 3) != 0);
            s.d     = $urandom;
            s.t     = 5'($urandom_range(0, 7));
            s.w     = 1'($urandom_range(0, 1));
            for (int k = 0; k < DEPTH; k++) s.stall[k] = ($urandom_range(0, 4) == 0);
            s.flush = ($urandom_range(0, 15) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
            s.lk0   = 5'($urandom_range(0, 7));
            s.lk1   = 5'($urandom_range(0, 7));
            drive(s);
        end
        idle(5);
        chk("sb_drained", sb_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pipe_chain.md
Name: pipe_chain

Overview:
- Parametrised pipeline-register chain of DEPTH stages; generalises the per-stage IF/ID, ID/EX, EX/MEM and MEM/WB latch groups into one block.
- Each stage carries a valid bit, a WIDTH-bit payload, a TAG_W destination-register tag and a write-enable flag.
- Supports per-stage stall with backward stall propagation, bubble insertion, and younger-stage flush.
- Provides LOOKUPS parallel tag-match ports for forwarding and hazard detection in the surrounding CPU.

Parameters:
- WIDTH, 32, payload bits per stage.
- DEPTH, 3, number of stages (min 1); stage 0 is youngest.
- TAG_W, 5, destination-register tag width.
- LOOKUPS, 2, number of forwarding lookup ports.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- in_valid  in  1  entry offered to stage 0.
- in_ready  out  1  stage 0 can accept this cycle.
- in_data  in  WIDTH  payload.
- in_tag  in  TAG_W  destination tag.
- in_wen  in  1  entry writes a register.
- stall_i  in  DEPTH  per-stage hold request.
- flush_i  in  DEPTH  flush_i[k] kills stages 0..k.
- out_valid  out  1  last stage valid.
- out_fire  out  1  out_valid & !stall_i[DEPTH-1].
- out_data  out  WIDTH  last-stage payload.
- out_tag  out  TAG_W  last-stage tag.
- out_wen  out  1  last-stage write-enable.
- lk_tag  in  LOOKUPS*TAG_W  lookup tags.
- lk_hit  out  LOOKUPS  match found.
- lk_stage  out  LOOKUPS*SIDX_W  stage index of the match.
- lk_data  out  LOOKUPS*WIDTH  payload of the match.
- occupancy  out  SIDX_W+1  count of valid stages.

Behaviour:
- Reset (synchronous, on rst high at the clock edge): every stage valid=0, data=0, tag=0, wen=0.
  - Hence out_valid=0, out_data=0, out_tag=0, out_wen=0, occupancy=0.
  - Reset mid-stream discards all entries; rst overrides every other input.
- Hold chain:
  - hold[DEPTH-1] = stall_i[DEPTH-1].
  - hold[k] = stall_i[k] | (hold[k+1] & valid[k]).
  - An empty stage never propagates a stall, so bubbles are collapsed.
  - in_ready = !hold[0]; this is combinational.
- Advance: when hold[k]=0:
  - stage k loads stage k-1 if stage k-1 is valid and not held.
  - Otherwise stage k loads a bubble (valid=0, data/tag/wen unchanged).
  - Stage 0 loads the input when in_valid & in_ready.
  - Held stages keep their contents.
- Latency: DEPTH cycles from input accept to out_valid when there are no stalls. Throughput is 1 entry per cycle.
- Flush:
  - Let F = highest k with flush_i[k]=1. At the next edge stages 0..F get valid=0.
  - The input accepted that cycle is dropped, but counts as consumed because in_ready was high.
  - Stages above F advance normally. Flush beats stall on flushed stages.
- Flush of the last stage:
  - flush_i[DEPTH-1] kills every stage.
  - out_fire is still computed from the pre-edge state: an entry firing in that cycle is delivered, and the flush takes effect on later cycles only.
- Lookup (combinational), per port j:
  - Candidates are stages with valid=1, wen=1 and tag==lk_tag[j].
  - lk_tag[j]==0 never hits (register zero).
  - The youngest (lowest index) candidate wins; lk_stage/lk_data come from that stage.
  - With no hit: lk_hit=0, lk_stage=0, lk_data=0.
- Arithmetic:
  - SIDX_W = max(1, clog2(DEPTH)).
  - occupancy is the popcount of the valid bits and is registered-state derived, with no wrap.

Optional Feature:
- Macro: PIPE_CHAIN_STATS_EN.
- Defined: adds three 32-bit saturating counters, each cleared by rst:
  - stat_stall, output port of width 32, counts cycles with in_valid & !in_ready.
  - stat_bubble, output port of width 32, counts cycles with !out_valid.
  - stat_flush, output port of width 32, counts valid entries killed by flush. Per cycle it adds the popcount of the killed stages.
  - Counters hold at 0xFFFFFFFF once reached.
- Undefined: these ports and all counter logic are absent; the rest of the behaviour is identical.

Decomposition:
- Shared package pipe_pkg holds:
  - the stage-entry struct typedef (valid, wen, tag, data);
  - the TAG_ZERO constant;
  - the SIDX_W helper function.
- One natural sub-module, pipe_stage_reg: a single stage register with load/hold/bubble/kill controls and synchronous reset. It is instantiated DEPTH times with a generate loop.
- Hold chain, flush mask and lookup priority encoders live in pipe_chain.

Test Plan:
1. Reset/stream (DEPTH=3): assert rst 2 cycles, then push A=0x11 (tag 3), B=0x22, C=0x33 on consecutive cycles -> out_valid first rises 3 cycles after A is accepted; outputs appear in order A, B, C; occupancy reaches 3.
2. Stall propagation: fill all stages, assert stall_i[2] for 2 cycles -> in_ready=0 for 2 cycles and contents unchanged. With only stage 2 valid, stall_i[2]=1 -> in_ready stays 1 and the bubbles fill.
3. Flush: entries in stages 0 and 1 plus input D offered, flush_i=3'b010 -> next cycle stages 0 and 1 are invalid, D is dropped, stage 2 advances; occupancy equals 1 if stage 1 was valid, else 0.
4. Lookup priority: stage 0 tag 5 data 0xAA wen=1, stage 2 tag 5 data 0xBB wen=1 -> lk_tag=5 gives lk_hit=1, lk_stage=0, lk_data=0xAA. Tag 0 in any stage gives lk_hit=0. A match with wen=0 gives no hit.
5. Reset mid-operation: full pipe with stall_i=3'b100 asserted, then rst for 1 cycle -> all outputs 0 next cycle and in_ready=1.
6. Stats (macro defined): 4 cycles of in_valid with in_ready=0, then flush 2 valid entries -> stat_stall=4, stat_flush=2; preload a counter near saturation via a long run and confirm it holds at 0xFFFFFFFF.
